// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: data width, reset/NOP constants and
// the fetch-stage state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the fetch stage: pc+4, branch/jal
// target or masked jalr target, plus detection of misaligned redirects.
module pc_next_logic
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] target_addr,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic [XLEN-1:0] jalr_target;

  assign jalr_target = {target_addr[XLEN-1:1], 1'b0};

  // jalr outranks jal/branch; its bit 0 is cleared before the alignment test
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    misalign = 1'b0;
    if (jalr) begin
      next_pc  = jalr_target;
      misalign = jalr_target[1];
    end else if (jal || branch_taken) begin
      next_pc  = target_addr;
      misalign = |target_addr[1:0];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid
// port and presents one instruction at a time to decode until it retires.
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        core_ready,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] target_addr,
  output logic [31:0] instruction,
  output logic [31:0] program_counter,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic [31:0] instret
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instruction_q, instruction_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misalign_err_q, misalign_err_d;

  logic [XLEN-1:0] next_pc;
  logic            next_misalign;

  pc_next_logic u_pc_next_logic (
    .pc           (pc_q),
    .jal          (jal),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .target_addr  (target_addr),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .misalign     (next_misalign)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instruction_d  = instruction_q;
    instret_d      = instret_q;
    instr_valid_d  = instr_valid_q;
    misalign_err_d = misalign_err_q;

    case (state_q)
      FETCH: begin
        if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instruction_d = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        // Retirement: a misaligned redirect still counts the instruction but parks the stage
        if (core_ready) begin
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
          instruction_d = NOP_INSTR;
          if (next_misalign) begin
            misalign_err_d = 1'b1;
            state_d        = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      instruction_q  <= NOP_INSTR;
      instret_q      <= '0;
      instr_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instruction_q  <= instruction_d;
      instret_q      <= instret_d;
      instr_valid_q  <= instr_valid_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // The request is suppressed while reset is held so nothing is issued before the stage is live
  assign imem_req        = (state_q == FETCH) && !rst;
  assign imem_addr       = pc_q;
  assign program_counter = pc_q;
  assign instruction     = instruction_q;
  assign instr_valid     = instr_valid_q;
  assign misalign_err    = misalign_err_q;
  assign instret         = instret_q;

endmodule
